// File: rtl/mvu_pkg.sv
// Shared MVU constants and the result-read client state encoding.
package mvu_pkg;

    localparam int unsigned BDBANKA = 15;
    localparam int unsigned BDBANKW = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rdc_state_t;

endpackage

// File: rtl/mvu_rdc_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is legal when it pops
// in the same cycle.
module mvu_rdc_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // The reader's credit rule must make this unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/mvu_rdc_reader.sv
// MVU result-read initiator: fetches a contiguous word block over the rdc port and
// streams it out in order through a credit-managed FIFO.
module mvu_rdc_reader #(
    parameter int unsigned BDBANKA = mvu_pkg::BDBANKA,
    parameter int unsigned BDBANKW = mvu_pkg::BDBANKW,
    parameter int unsigned CNTW    = 16,
    parameter int unsigned RDLAT   = 1,
    parameter int unsigned FDEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BDBANKA-1:0] base_addr,
    input  logic [CNTW-1:0]    count,
    output logic               busy,
    output logic               done,
    output logic               rdc_en,
    input  logic               rdc_grnt,
    output logic [BDBANKA-1:0] rdc_addr,
    input  logic [BDBANKW-1:0] rdc_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BDBANKW-1:0] out_data,
    output logic               out_last
);
    import mvu_pkg::*;

    localparam int unsigned CW = $clog2(FDEPTH + 1);
    localparam int unsigned SW = CW + 1;

    rdc_state_t         r_state, w_state_nxt;
    logic [BDBANKA-1:0] r_addr, w_addr_nxt;
    logic [CNTW-1:0]    r_req_left, w_req_left_nxt;
    logic [CNTW-1:0]    r_out_left, w_out_left_nxt;
    logic               r_rdc_en, w_rdc_en_nxt;
    logic               r_done, w_done_nxt;
    logic [RDLAT-1:0]   r_vld_sr, w_vld_sr_nxt;
    logic [SW-1:0]      r_inflight, w_inflight_nxt, w_credit_nxt;
    logic [CW-1:0]      w_fifo_count;
    logic               w_empty;
    logic               w_grant, w_exit, w_pop, w_last_pop;

    assign w_grant    = r_rdc_en && rdc_grnt;
    assign w_exit     = r_vld_sr[RDLAT-1];
    assign w_pop      = !w_empty && out_ready;
    assign w_last_pop = w_pop && (r_out_left == CNTW'(1));

    mvu_rdc_fifo #(
        .WIDTH (BDBANKW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_exit),
        .i_wdata (rdc_word),
        .i_pop   (w_pop),
        .o_rdata (out_data),
        .o_count (w_fifo_count),
        .o_full  (),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_req_left_nxt = r_req_left;
        w_out_left_nxt = r_out_left - CNTW'(w_pop);
        w_done_nxt     = 1'b0;
        w_vld_sr_nxt   = RDLAT'({r_vld_sr, w_grant});
        w_inflight_nxt = r_inflight + SW'(w_grant) - SW'(w_exit);
        // Tokens moving from the shift register into the FIFO leave the sum unchanged.
        w_credit_nxt   = SW'(w_fifo_count) + r_inflight + SW'(w_grant) - SW'(w_pop);

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_state_nxt    = ISSUE;
                        w_addr_nxt     = base_addr;
                        w_req_left_nxt = count;
                        w_out_left_nxt = count;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (w_grant) begin
                    w_addr_nxt     = r_addr + BDBANKA'(1);
                    w_req_left_nxt = r_req_left - CNTW'(1);
                    if (r_req_left == CNTW'(1)) w_state_nxt = DRAIN;
                end
            end
            DRAIN: ;
            default: w_state_nxt = IDLE;
        endcase

        if (w_last_pop && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
        end

        w_rdc_en_nxt = (w_state_nxt == ISSUE) && (w_req_left_nxt != '0) &&
                       (w_credit_nxt < SW'(FDEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_req_left <= '0;
            r_out_left <= '0;
            r_rdc_en   <= 1'b0;
            r_done     <= 1'b0;
            r_vld_sr   <= '0;
            r_inflight <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_req_left <= w_req_left_nxt;
            r_out_left <= w_out_left_nxt;
            r_rdc_en   <= w_rdc_en_nxt;
            r_done     <= w_done_nxt;
            r_vld_sr   <= w_vld_sr_nxt;
            r_inflight <= w_inflight_nxt;
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign rdc_en    = r_rdc_en;
    assign rdc_addr  = r_addr;
    assign out_valid = !w_empty;
    assign out_last  = !w_empty && (r_out_left == CNTW'(1));

endmodule
